// File: rtl/output_arbiter.sv
// output_arbiter: round-robin packet arbiter for one egress port; define ARB_TIMEOUT_EN to force release after MAX_PKT_WORDS words.
module output_arbiter #(
    parameter int NUM_PORTS     = 4,
    parameter int SEL_W         = 2,
    parameter int MAX_PKT_WORDS = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] req,
    input  logic [NUM_PORTS-1:0] eop,
    input  logic                 out_ready,
    output logic [NUM_PORTS-1:0] gnt,
    output logic [SEL_W-1:0]     mux_sel,
    output logic                 arb_active,
    output logic                 timeout_err
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t               state, state_n;
    logic [NUM_PORTS-1:0] gnt_n;
    logic [SEL_W-1:0]     sel_n, rr_ptr, ptr_n, win;
    logic                 found, end_pkt, timeout_hit, new_grant;
    if (NUM_PORTS != 4 || SEL_W != 2 || MAX_PKT_WORDS < 1) begin : g_cfg_check
        $error("output_arbiter supports only a 4-port, 2-bit select configuration");
    end
    assign arb_active = state == BUSY && out_ready;
    assign end_pkt    = arb_active && (eop[mux_sel] || timeout_hit);
    assign new_grant  = (state == IDLE || end_pkt) && found;
    // rr_ptr already sits past the last owner, so a plain search from it leaves the owner last
    always_comb begin
        win   = rr_ptr;
        found = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!found && req[rr_ptr + SEL_W'(i)]) begin
                win   = rr_ptr + SEL_W'(i);
                found = 1'b1;
            end
        end
    end
    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        sel_n   = mux_sel;
        ptr_n   = rr_ptr;
        if (new_grant) begin
            state_n = BUSY;
            gnt_n   = NUM_PORTS'(1) << win;
            sel_n   = win;
            ptr_n   = win + SEL_W'(1);
        end else if (state == BUSY && (end_pkt || !req[mux_sel])) begin
            state_n = IDLE;
            gnt_n   = '0;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            gnt     <= '0;
            mux_sel <= '0;
            rr_ptr  <= '0;
        end else begin
            state   <= state_n;
            gnt     <= gnt_n;
            mux_sel <= sel_n;
            rr_ptr  <= ptr_n;
        end
    end
`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(MAX_PKT_WORDS) + 1;
    logic [CW-1:0] word_cnt;
    assign timeout_hit = arb_active && !eop[mux_sel] && word_cnt == CW'(MAX_PKT_WORDS - 1);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            word_cnt    <= new_grant ? '0 : word_cnt + CW'(arb_active);
            timeout_err <= timeout_hit;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_output_arbiter.sv
// tb_output_arbiter: directed scenarios plus randomized traffic against a packet-level reference model.
module tb_output_arbiter;
    localparam int MAXW = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO = 1'b1;
`else
    localparam bit TO = 1'b0;
`endif
    logic       clk = 1'b0, rst_n = 1'b0, out_ready = 1'b0;
    logic [3:0] req = '0, eop = '0;
    logic [3:0] gnt;
    logic [1:0] mux_sel;
    logic       arb_active, timeout_err;
    int         n_cmp = 0, n_bad = 0;
    bit         m_busy, m_to;
    int         m_owner, m_ptr, m_cnt;

    output_arbiter #(.NUM_PORTS(4), .SEL_W(2), .MAX_PKT_WORDS(MAXW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .eop(eop), .out_ready(out_ready),
        .gnt(gnt), .mux_sel(mux_sel), .arb_active(arb_active), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        m_busy  = 1'b0;
        m_to    = 1'b0;
        m_owner = 0;
        m_ptr   = 0;
        m_cnt   = 0;
    endtask

    // One clock edge of the packet-level behaviour, using the inputs currently applied
    task automatic model_edge;
        bit active, ended;
        int w;
        if (!rst_n) begin
            model_reset();
            return;
        end
        active = m_busy && out_ready;
        ended  = active && (eop[m_owner] || (TO && m_cnt + 1 >= MAXW));
        m_to   = TO && active && !eop[m_owner] && (m_cnt + 1 == MAXW);
        w = -1;
        for (int k = 0; k < 4; k++)
            if (w < 0 && req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
        if ((!m_busy || ended) && w >= 0) begin
            m_busy  = 1'b1;
            m_owner = w;
            m_ptr   = (w + 1) % 4;
            m_cnt   = 0;
        end else if (m_busy && (ended || !req[m_owner])) begin
            m_busy = 1'b0;
        end else if (active) begin
            m_cnt++;
        end
    endtask

    task automatic apply_reset;
        rst_n = 1'b0;
        req = '0;
        eop = '0;
        out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req = 4'b1111;
        eop = '0;
        out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_cmp++;
            if (gnt !== 4'b0 || mux_sel !== 2'd0 || arb_active !== 1'b0 || timeout_err !== 1'b0) begin
                n_bad++;
                $display("FAIL reset cyc%0d: gnt=%b mux_sel=%0d arb_active=%b timeout_err=%b, required 0000/0/0/0",
                         c, gnt, mux_sel, arb_active, timeout_err);
            end
        end
        rst_n = 1'b1;
        req = '0;
        tick();
        n_cmp++;
        if (gnt !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_idle: gnt=%b, required 0000", gnt);
        end
    endtask

    task automatic test_single_source;
        int words = 0, cyc = 0;
        req = 4'b0100;
        out_ready = 1'b1;
        eop = '0;
        tick();
        n_cmp++;
        if (gnt !== 4'b0100 || mux_sel !== 2'd2) begin
            n_bad++;
            $display("FAIL single_grant: gnt=%b mux_sel=%0d, required 0100/2", gnt, mux_sel);
        end
        while (gnt !== 4'b0 && cyc < 10) begin
            eop = (words == 2) ? 4'b0100 : 4'b0;
            req = (words == 2) ? 4'b0 : 4'b0100;
            #1;
            if (arb_active) words++;
            tick();
            cyc++;
        end
        eop = '0;
        req = '0;
        n_cmp++;
        if (words != 3 || cyc != 3 || gnt !== 4'b0) begin
            n_bad++;
            $display("FAIL single_len: words=%0d cycles=%0d gnt=%b, required 3/3/0000", words, cyc, gnt);
        end
    endtask

    task automatic test_round_robin;
        logic [3:0] exp;
        apply_reset();
        req = 4'b1111;
        tick();
        for (int k = 0; k < 10; k++) begin
            exp = 4'b0001 << ((k / 2) % 4);
            n_cmp++;
            if (gnt !== exp || mux_sel !== 2'((k / 2) % 4)) begin
                n_bad++;
                $display("FAIL rr_order k=%0d: gnt=%b mux_sel=%0d, required %b/%0d", k, gnt, mux_sel, exp, (k / 2) % 4);
            end
            eop = (k % 2 == 1) ? exp : 4'b0;
            tick();
        end
        eop = '0;
        req = '0;
    endtask

    task automatic test_backpressure;
        int words = 0;
        apply_reset();
        req = 4'b0010;
        tick();
        n_cmp++;
        if (gnt !== 4'b0010) begin
            n_bad++;
            $display("FAIL bp_grant: gnt=%b, required 0010", gnt);
        end
        #1;
        if (arb_active) words++;
        tick();
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_cmp++;
            if (gnt !== 4'b0010 || mux_sel !== 2'd1 || arb_active !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_stall cyc%0d: gnt=%b mux_sel=%0d arb_active=%b, required 0010/1/0", c, gnt, mux_sel, arb_active);
            end
            if (arb_active) words++;
            tick();
        end
        n_cmp++;
        if (words != 1) begin
            n_bad++;
            $display("FAIL bp_words_held: words=%0d, required 1", words);
        end
        out_ready = 1'b1;
        eop = 4'b0010;
        req = '0;
        #1;
        if (arb_active) words++;
        tick();
        eop = '0;
        n_cmp++;
        if (words != 2 || gnt !== 4'b0) begin
            n_bad++;
            $display("FAIL bp_end: words=%0d gnt=%b, required 2/0000", words, gnt);
        end
    endtask

    task automatic test_abort;
        apply_reset();
        req = 4'b1000;
        tick();
        n_cmp++;
        if (gnt !== 4'b1000 || mux_sel !== 2'd3) begin
            n_bad++;
            $display("FAIL abort_grant: gnt=%b mux_sel=%0d, required 1000/3", gnt, mux_sel);
        end
        tick();
        req = 4'b0001;
        tick();
        n_cmp++;
        if (gnt !== 4'b0) begin
            n_bad++;
            $display("FAIL abort_idle: gnt=%b, required 0000", gnt);
        end
        tick();
        n_cmp++;
        if (gnt !== 4'b0001 || mux_sel !== 2'd0) begin
            n_bad++;
            $display("FAIL abort_regrant: gnt=%b mux_sel=%0d, required 0001/0", gnt, mux_sel);
        end
        req = '0;
        tick();
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout;
        int words = 0, pulses = 0, cyc = 0;
        logic [3:0] next_gnt;
        apply_reset();
        req = 4'b0011;
        tick();
        n_cmp++;
        if (gnt !== 4'b0001) begin
            n_bad++;
            $display("FAIL to_grant: gnt=%b, required 0001", gnt);
        end
        while (gnt === 4'b0001 && cyc < 20) begin
            #1;
            if (arb_active) words++;
            tick();
            cyc++;
            if (timeout_err) pulses++;
        end
        next_gnt = gnt;
        tick();
        if (timeout_err) pulses++;
        n_cmp++;
        if (words != MAXW || next_gnt !== 4'b0010 || pulses != 1) begin
            n_bad++;
            $display("FAIL timeout: words=%0d next_gnt=%b pulses=%0d, required %0d/0010/1", words, next_gnt, pulses, MAXW);
        end
        req = '0;
    endtask
`else
    task automatic test_timeout;
        int bad_cyc = 0;
        apply_reset();
        req = 4'b0001;
        tick();
        for (int c = 0; c < 80; c++) begin
            tick();
            if (gnt !== 4'b0001 || timeout_err !== 1'b0) bad_cyc++;
        end
        n_cmp++;
        if (bad_cyc != 0) begin
            n_bad++;
            $display("FAIL long_packet: %0d cycles lost grant or pulsed timeout_err, required 0", bad_cyc);
        end
        req = '0;
    endtask
`endif

    task automatic test_random;
        logic [3:0] exp_gnt;
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            req = 4'($urandom_range(0, 15));
            if (m_busy && $urandom_range(0, 7) != 0) req[m_owner] = 1'b1;
            eop = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) != 0) eop[m_owner] = 1'b0;
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            n_cmp++;
            if (arb_active !== (m_busy && out_ready)) begin
                n_bad++;
                $display("FAIL rnd_active c=%0d: arb_active=%b, required %b", c, arb_active, m_busy && out_ready);
            end
            model_edge();
            tick();
            exp_gnt = m_busy ? 4'(1 << m_owner) : 4'b0;
            n_cmp++;
            if (gnt !== exp_gnt || timeout_err !== m_to || (m_busy && mux_sel !== m_owner[1:0])) begin
                n_bad++;
                $display("FAIL rnd_out c=%0d: gnt=%b mux_sel=%0d timeout_err=%b, required %b/%0d/%b",
                         c, gnt, mux_sel, timeout_err, exp_gnt, m_owner, m_to);
            end
        end
        rst_n = 1'b1;
        req = '0;
        eop = '0;
    endtask

    initial begin
        test_reset();
        test_single_source();
        test_round_robin();
        test_backpressure();
        test_abort();
        test_timeout();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
